// File: rtl/nios_mul_combine.sv
// nios_mul_combine: combines 16x16 multiply-cell partials into MUL low word or MULX high word
module nios_mul_combine #(
    parameter int STEP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    input  logic        abort,
    output logic        out_valid,
    output logic [31:0] out_result
);
    localparam int N = 16 / STEP_BITS;

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t      state, state_nxt;
    logic [32:0] mid, lowsum;
    logic [17:0] hi_add, hi_add_q;
    logic [31:0] a_q, b_q, acc, step_prod, hi;
    logic [15:0] mcand, mplier;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        accept, last, sign_a, sign_b;

    assign mid       = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
    assign lowsum    = {1'b0, M_mul_cell_p1} + {1'b0, mid[15:0], 16'b0};
    assign hi_add    = {1'b0, mid[32:16]} + 18'(lowsum[32]);
    assign in_ready  = state == IDLE;
    assign accept    = in_valid & in_ready & ~abort;
    assign last      = cnt == 5'(N - 1);
    assign step_prod = 32'(mcand) * 32'(mplier[STEP_BITS-1:0]);
    assign sign_a    = a_q[31] & op_q[1];
    assign sign_b    = b_q[31] & (op_q == 2'd3);
    assign hi        = acc + 32'(hi_add_q) - (sign_a ? b_q : 32'd0) - (sign_b ? a_q : 32'd0);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state: abort wins over everything, MUL never leaves IDLE
    always_comb begin
        state_nxt = state;
        if (abort)                                      state_nxt = IDLE;
        else if (state == IDLE && accept && in_op != 0) state_nxt = ITER;
        else if (state == ITER && last)                 state_nxt = FIN;
        else if (state == FIN)                          state_nxt = IDLE;
    end

    // datapath: operand capture, shift-add hi*hi engine, result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            hi_add_q   <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE && accept) begin
                if (in_op == 2'd0) begin
                    out_result <= lowsum[31:0];
                    out_valid  <= 1'b1;
                end else begin
                    a_q      <= in_src1;
                    b_q      <= in_src2;
                    op_q     <= in_op;
                    hi_add_q <= hi_add;
                    acc      <= '0;
                    mcand    <= in_src1[31:16];
                    mplier   <= in_src2[31:16];
                    cnt      <= '0;
                end
            end else if (!abort && state == ITER) begin
                acc    <= acc + (step_prod << (cnt * STEP_BITS));
                mplier <= mplier >> STEP_BITS;
                cnt    <= cnt + 5'd1;
            end else if (!abort && state == FIN) begin
                out_result <= hi;
                out_valid  <= 1'b1;
            end
        end
    end
endmodule
